traffic_stats_axil_slave: RTL and testbench
===========================================

Name: traffic_stats_axil_slave

Overview:
- AXI4-Lite responder (slave) that answers the register reads and writes the PS master issues to a traffic analyzer instance: ID, FLIP scratch, CONTROL and 64-bit statistics counters.
- Sits between the AXI interconnect and the analyzer datapath.
- Drives the enable/freeze controls and returns counter values.
- 64-bit counters are read as hi word then lo word; the hi read snapshots the lo word so the pair is coherent.

Parameters:
- C_S_AXI_ADDR_WIDTH, 8, byte address width; decode uses addr[7:2].
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- IP_ID, 32'h0000A0A1, value returned at offset 0x00.
- IP_VERSION, 32'h00010000, value returned at offset 0x04.

Ports:
- aclk  in  1  clock for all logic.
- rst  in  1  synchronous, active-high reset.
- s_axi_awaddr  in  8  write address.
- s_axi_awvalid in 1, s_axi_awready out 1: AW handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte enables.
- s_axi_wvalid in 1, s_axi_wready out 1: W handshake.
- s_axi_bresp out 2, s_axi_bvalid out 1, s_axi_bready in 1: write response.
- s_axi_araddr  in  8  read address.
- s_axi_arvalid in 1, s_axi_arready out 1: AR handshake.
- s_axi_rdata out 32, s_axi_rresp out 2, s_axi_rvalid out 1, s_axi_rready in 1: read data.
- ctrl_enable  out  1  CONTROL[0].
- ctrl_freeze  out  1  CONTROL[1].
- stat_pkts  in  64  packet count.
- stat_octets  in  64  octet count.
- stat_octets_idle  in  64  idle octet count.
- stat_bad_crc_pkts  in  64  bad-CRC packet count.
- stat_latency_min  in  32  minimum latency in ns.

Behaviour:
- Register map (offsets):
  - 0x00 ID, RO.
  - 0x04 VERSION, RO.
  - 0x0C FLIP, RW; a read returns the bitwise inverse of the stored value.
  - 0x10 CONTROL, RW; bits [1:0] only, upper bits read 0.
  - 0x20/0x24 PKTS hi/lo.
  - 0x28/0x2C OCTETS hi/lo.
  - 0x30/0x34 OCTETS_IDLE hi/lo.
  - 0x58/0x5C BAD_CRC_PKTS hi/lo.
  - 0x98 LATENCY_MIN_NSEC.
  - All counter registers are RO.
- Reset (rst=1 at a rising edge):
  - awready, wready, arready, bvalid and rvalid = 0.
  - bresp, rresp and rdata = 0.
  - FLIP store = 0, so FLIP reads 0xFFFFFFFF.
  - CONTROL = 0, so ctrl_enable = ctrl_freeze = 0.
  - All lo shadows = 0.
- Reset mid-transaction drops the transaction; no response is issued.
- Write path state machine, states W_IDLE -> W_RESP -> W_IDLE:
  - In W_IDLE, awready and wready are asserted. AW and W are captured independently, each into a one-entry holding register; the matching ready deasserts once its register is full.
  - When both registers are full, the write is committed in that cycle. FLIP and CONTROL honor wstrb per byte lane. bvalid rises on the next cycle.
  - W_RESP holds bvalid and bresp stable until bready. On bvalid&&bready, return to W_IDLE and re-assert the readies the following cycle.
  - Only one write is outstanding at a time.
- Write responses:
  - Writes to FLIP or CONTROL: bresp = OKAY (2'b00).
  - Writes to RO or unmapped offsets: no state change; bresp = SLVERR (2'b10).
- Read path state machine, states R_IDLE -> R_DATA -> R_IDLE:
  - arready = 1 in R_IDLE. On arvalid&&arready, decode; rdata, rresp and rvalid are registered on the next cycle (1-cycle latency).
  - rdata and rresp are held stable until rready; then return to R_IDLE.
  - Read responses:
    - Mapped offsets: rresp = OKAY.
    - Unmapped offsets: rdata = 0, rresp = SLVERR.
- Counter coherency:
  - A read of a hi word returns input[63:32] sampled at the AR handshake cycle, and the same cycle captures input[31:0] into that counter's lo shadow.
  - A lo read returns the shadow, not the live input.
  - Each of the four counters has its own shadow.
  - A lo read with no prior hi read returns the reset shadow, 0.
- Simultaneous events:
  - The read and write channels operate concurrently.
  - A read and a committing write to the same register in the same cycle: the read returns the old value.
  - CONTROL outputs change in the cycle after the write commits.
- Offsets not word-aligned: addr[1:0] is ignored.

Test Plan:
- Reset, then read 0x00 and 0x0C -> rdata = IP_ID with OKAY, then 0xFFFFFFFF; rvalid exactly one cycle after the AR handshake.
- Write 0x12345678 to 0x0C, read 0x0C -> 0xEDCBA987. Write wstrb=4'b0001 data 0xFF -> read 0xEDCBA900.
- Present W three cycles before AW -> one bvalid after both are captured, bresp = OKAY. Hold bready low for 5 cycles -> bvalid and bresp stay stable.
- Write 0x3 to 0x10 -> ctrl_enable = ctrl_freeze = 1 the cycle after commit. Assert rst mid-read -> rvalid = 0, ctrl outputs = 0.
- Set stat_octets = 0x00000001_FFFFFFFF, read 0x28, then change the input to 0x00000002_00000000, read 0x2C -> 0x00000001 then 0xFFFFFFFF.
- Read 0x40 and write 0x00 -> rresp = 2'b10 with rdata = 0, and bresp = 2'b10 with ID unchanged.

Source files
------------

// File: rtl/traffic_stats_axil_slave_if.sv
// AXI4-Lite bus bundle between the PS interconnect master and the traffic
// statistics register slave.
//   AW: s_axi_awaddr/awvalid/awready     W: s_axi_wdata/wstrb/wvalid/wready
//   B : s_axi_bresp/bvalid/bready        AR: s_axi_araddr/arvalid/arready
//   R : s_axi_rdata/rresp/rvalid/rready
interface traffic_stats_axil_slave_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) ();
  logic [ADDR_W-1:0]   s_axi_awaddr;
  logic                s_axi_awvalid;
  logic                s_axi_awready;
  logic [DATA_W-1:0]   s_axi_wdata;
  logic [DATA_W/8-1:0] s_axi_wstrb;
  logic                s_axi_wvalid;
  logic                s_axi_wready;
  logic [1:0]          s_axi_bresp;
  logic                s_axi_bvalid;
  logic                s_axi_bready;
  logic [ADDR_W-1:0]   s_axi_araddr;
  logic                s_axi_arvalid;
  logic                s_axi_arready;
  logic [DATA_W-1:0]   s_axi_rdata;
  logic [1:0]          s_axi_rresp;
  logic                s_axi_rvalid;
  logic                s_axi_rready;

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/traffic_stats_axil_slave.sv
// AXI4-Lite register slave for the traffic analyzer: ID/VERSION, FLIP scratch,
// CONTROL (enable/freeze) and 64-bit statistics counters read hi-then-lo.
// Ports:
//   aclk, rst            clock, synchronous active-high reset
//   s_axi                AXI4-Lite slave bundle (traffic_stats_axil_slave_if.slave)
//   ctrl_enable/freeze   CONTROL[0]/CONTROL[1]
//   stat_*               live counter inputs from the analyzer datapath
module traffic_stats_axil_slave #(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 8,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter logic [31:0] IP_ID      = 32'h0000A0A1,
  parameter logic [31:0] IP_VERSION = 32'h00010000
) (
  input  logic        aclk,
  input  logic        rst,
  traffic_stats_axil_slave_if.slave s_axi,
  output logic        ctrl_enable,
  output logic        ctrl_freeze,
  input  logic [63:0] stat_pkts,
  input  logic [63:0] stat_octets,
  input  logic [63:0] stat_octets_idle,
  input  logic [63:0] stat_bad_crc_pkts,
  input  logic [31:0] stat_latency_min
);
  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW = DW / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Word indices (byte offset >> 2)
  localparam logic [5:0] IDX_ID       = 6'h00;
  localparam logic [5:0] IDX_VERSION  = 6'h01;
  localparam logic [5:0] IDX_FLIP     = 6'h03;
  localparam logic [5:0] IDX_CONTROL  = 6'h04;
  localparam logic [5:0] IDX_PKTS_HI  = 6'h08;
  localparam logic [5:0] IDX_PKTS_LO  = 6'h09;
  localparam logic [5:0] IDX_OCT_HI   = 6'h0A;
  localparam logic [5:0] IDX_OCT_LO   = 6'h0B;
  localparam logic [5:0] IDX_IDLE_HI  = 6'h0C;
  localparam logic [5:0] IDX_IDLE_LO  = 6'h0D;
  localparam logic [5:0] IDX_CRC_HI   = 6'h16;
  localparam logic [5:0] IDX_CRC_LO   = 6'h17;
  localparam logic [5:0] IDX_LAT_MIN  = 6'h26;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [0:0]    w_state, w_state_next;
  logic [0:0]    r_state, r_state_next;

  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [DW-1:0] rdata;

  logic          aw_full, w_full;
  logic [5:0]    aw_idx;
  logic [DW-1:0] w_data;
  logic [SW-1:0] w_strb;

  logic [DW-1:0] flip;
  logic [31:0]   pkts_lo, octets_lo, idle_lo, crc_lo;

  logic [AW-1:0] awaddr_c, araddr_c;
  logic [5:0]    ar_idx_c;
  logic          aw_hs_c, w_hs_c, ar_hs_c, b_hs_c, r_hs_c;
  logic          commit_c, wr_flip_c, wr_ctrl_c;
  logic [DW-1:0] rd_data_c;
  logic [1:0]    rd_resp_c;
  logic          unused_c;

  assign awaddr_c = s_axi.s_axi_awaddr;
  assign araddr_c = s_axi.s_axi_araddr;
  assign ar_idx_c = araddr_c[7:2];
  // Byte-lane bits of the address carry no meaning here
  assign unused_c = ^{awaddr_c[1:0], araddr_c[1:0]};

  assign s_axi.s_axi_awready = awready;
  assign s_axi.s_axi_wready  = wready;
  assign s_axi.s_axi_bvalid  = bvalid;
  assign s_axi.s_axi_bresp   = bresp;
  assign s_axi.s_axi_arready = arready;
  assign s_axi.s_axi_rvalid  = rvalid;
  assign s_axi.s_axi_rresp   = rresp;
  assign s_axi.s_axi_rdata   = rdata;

  assign aw_hs_c = s_axi.s_axi_awvalid && awready;
  assign w_hs_c  = s_axi.s_axi_wvalid && wready;
  assign b_hs_c  = bvalid && s_axi.s_axi_bready;
  assign ar_hs_c = s_axi.s_axi_arvalid && arready;
  assign r_hs_c  = rvalid && s_axi.s_axi_rready;

  // Write commits in the cycle both holding registers are full
  assign commit_c  = (w_state == W_IDLE) && aw_full && w_full;
  assign wr_flip_c = commit_c && (aw_idx == IDX_FLIP);
  assign wr_ctrl_c = commit_c && (aw_idx == IDX_CONTROL);

  // Next-state logic for both channel FSMs
  always_comb begin
    w_state_next = w_state;
    r_state_next = r_state;
    if (w_state == W_IDLE) begin
      if (commit_c) w_state_next = W_RESP;
    end else begin
      if (b_hs_c) w_state_next = W_IDLE;
    end
    if (r_state == R_IDLE) begin
      if (ar_hs_c) r_state_next = R_DATA;
    end else begin
      if (r_hs_c) r_state_next = R_IDLE;
    end
  end

  // Read decode; sees register values before any same-cycle write commit
  always_comb begin
    rd_data_c = '0;
    rd_resp_c = RESP_OKAY;
    case (ar_idx_c)
      IDX_ID:      rd_data_c = IP_ID;
      IDX_VERSION: rd_data_c = IP_VERSION;
      IDX_FLIP:    rd_data_c = ~flip;
      IDX_CONTROL: rd_data_c = {30'd0, ctrl_freeze, ctrl_enable};
      IDX_PKTS_HI: rd_data_c = stat_pkts[63:32];
      IDX_PKTS_LO: rd_data_c = pkts_lo;
      IDX_OCT_HI:  rd_data_c = stat_octets[63:32];
      IDX_OCT_LO:  rd_data_c = octets_lo;
      IDX_IDLE_HI: rd_data_c = stat_octets_idle[63:32];
      IDX_IDLE_LO: rd_data_c = idle_lo;
      IDX_CRC_HI:  rd_data_c = stat_bad_crc_pkts[63:32];
      IDX_CRC_LO:  rd_data_c = crc_lo;
      IDX_LAT_MIN: rd_data_c = stat_latency_min;
      default:     rd_resp_c = RESP_SLVERR;
    endcase
  end

  // Write channel: AW/W holding registers, commit, B response, writable regs
  always_ff @(posedge aclk) begin
    if (rst) begin
      w_state     <= W_IDLE;
      awready     <= 1'b0;
      wready      <= 1'b0;
      aw_full     <= 1'b0;
      w_full      <= 1'b0;
      aw_idx      <= '0;
      w_data      <= '0;
      w_strb      <= '0;
      bvalid      <= 1'b0;
      bresp       <= RESP_OKAY;
      flip        <= '0;
      ctrl_enable <= 1'b0;
      ctrl_freeze <= 1'b0;
    end else begin
      w_state <= w_state_next;
      if (w_state == W_IDLE) begin
        if (commit_c) begin
          aw_full <= 1'b0;
          w_full  <= 1'b0;
          bvalid  <= 1'b1;
          bresp   <= (wr_flip_c || wr_ctrl_c) ? RESP_OKAY : RESP_SLVERR;
        end else begin
          if (aw_hs_c) begin
            aw_full <= 1'b1;
            aw_idx  <= awaddr_c[7:2];
            awready <= 1'b0;
          end else if (!aw_full) begin
            awready <= 1'b1;
          end
          if (w_hs_c) begin
            w_full <= 1'b1;
            w_data <= s_axi.s_axi_wdata;
            w_strb <= s_axi.s_axi_wstrb;
            wready <= 1'b0;
          end else if (!w_full) begin
            wready <= 1'b1;
          end
        end
      end else if (b_hs_c) begin
        bvalid  <= 1'b0;
        awready <= 1'b1;
        wready  <= 1'b1;
      end

      for (int i = 0; i < int'(SW); i++) begin
        if (wr_flip_c && w_strb[i]) flip[8*i +: 8] <= w_data[8*i +: 8];
      end
      if (wr_ctrl_c && w_strb[0]) begin
        ctrl_enable <= w_data[0];
        ctrl_freeze <= w_data[1];
      end
    end
  end

  // Read channel: one-cycle registered response; hi read snapshots lo half
  always_ff @(posedge aclk) begin
    if (rst) begin
      r_state   <= R_IDLE;
      arready   <= 1'b0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      rresp     <= RESP_OKAY;
      pkts_lo   <= '0;
      octets_lo <= '0;
      idle_lo   <= '0;
      crc_lo    <= '0;
    end else begin
      r_state <= r_state_next;
      if (r_state == R_IDLE) begin
        if (ar_hs_c) begin
          arready <= 1'b0;
          rvalid  <= 1'b1;
          rdata   <= rd_data_c;
          rresp   <= rd_resp_c;
          if (ar_idx_c == IDX_PKTS_HI) pkts_lo   <= stat_pkts[31:0];
          if (ar_idx_c == IDX_OCT_HI)  octets_lo <= stat_octets[31:0];
          if (ar_idx_c == IDX_IDLE_HI) idle_lo   <= stat_octets_idle[31:0];
          if (ar_idx_c == IDX_CRC_HI)  crc_lo    <= stat_bad_crc_pkts[31:0];
        end else begin
          arready <= 1'b1;
        end
      end else if (r_hs_c) begin
        rvalid  <= 1'b0;
        arready <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_traffic_stats_axil_slave.sv
// Self-checking bench for traffic_stats_axil_slave: constant vector table,
// hand-written corner sequences and a randomized phase against a register model.
module tb_traffic_stats_axil_slave;
  logic aclk = 1'b0;
  logic rst;
  logic ctrl_enable, ctrl_freeze;
  logic [63:0] st [4];
  logic [31:0] lat;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] ctrl_before, ctrl_at_b;

  // Register-level model
  logic [31:0] m_flip;
  logic [1:0]  m_ctrl;
  logic [31:0] m_shadow [4];
  localparam logic [7:0] HI_OFF [4] = '{8'h20, 8'h28, 8'h30, 8'h58};

  typedef struct {
    logic        is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;
  vec_t vecs [$];

  traffic_stats_axil_slave_if bus ();

  traffic_stats_axil_slave dut (
    .aclk              (aclk),
    .rst               (rst),
    .s_axi             (bus),
    .ctrl_enable       (ctrl_enable),
    .ctrl_freeze       (ctrl_freeze),
    .stat_pkts         (st[0]),
    .stat_octets       (st[1]),
    .stat_octets_idle  (st[2]),
    .stat_bad_crc_pkts (st[3]),
    .stat_latency_min  (lat)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: handshake timed out", name);
  endtask

  task automatic model_reset();
    m_flip = '0;
    m_ctrl = '0;
    for (int k = 0; k < 4; k++) m_shadow[k] = '0;
  endtask

  task automatic model_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    logic [7:0] off;
    off = {a[7:2], 2'b00};
    d = '0;
    r = 2'b00;
    case (off)
      8'h00: d = 32'h0000A0A1;
      8'h04: d = 32'h00010000;
      8'h0C: d = ~m_flip;
      8'h10: d = {30'd0, m_ctrl};
      8'h98: d = lat;
      default: begin
        r = 2'b10;
        for (int k = 0; k < 4; k++) begin
          if (off == HI_OFF[k]) begin
            d = st[k][63:32];
            m_shadow[k] = st[k][31:0];
            r = 2'b00;
          end else if (off == HI_OFF[k] + 8'd4) begin
            d = m_shadow[k];
            r = 2'b00;
          end
        end
      end
    endcase
  endtask

  task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
    logic [7:0] off;
    off = {a[7:2], 2'b00};
    r = 2'b10;
    if (off == 8'h0C) begin
      for (int b = 0; b < 4; b++) if (s[b]) m_flip[8*b +: 8] = d[8*b +: 8];
      r = 2'b00;
    end else if (off == 8'h10) begin
      if (s[0]) m_ctrl = d[1:0];
      r = 2'b00;
    end
  endtask

  // Called at posedge+1. AW/W raised at cycle aw_start/w_start; bready held low b_hold cycles.
  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int w_start, input int aw_start, input int b_hold,
                          input logic [1:0] exp_resp, input string name);
    bit aw_done, w_done, aw_hs, w_hs, got;
    int cyc;
    logic [1:0] prev_c;
    aw_done = 0; w_done = 0; got = 0; cyc = 0;
    bus.s_axi_awaddr = addr;
    bus.s_axi_wdata  = data;
    bus.s_axi_wstrb  = strb;
    bus.s_axi_bready = 1'b0;
    while (!(aw_done && w_done) && cyc < 40) begin
      if (cyc == aw_start) bus.s_axi_awvalid = 1'b1;
      if (cyc == w_start)  bus.s_axi_wvalid  = 1'b1;
      @(negedge aclk);
      aw_hs = bus.s_axi_awvalid && bus.s_axi_awready;
      w_hs  = bus.s_axi_wvalid && bus.s_axi_wready;
      @(posedge aclk); #1;
      if (aw_hs) begin bus.s_axi_awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin bus.s_axi_wvalid  = 1'b0; w_done  = 1; end
      cyc++;
    end
    if (!(aw_done && w_done)) begin
      bus.s_axi_awvalid = 1'b0;
      bus.s_axi_wvalid  = 1'b0;
      fail_timeout({name, "_aw_w"});
      return;
    end
    prev_c = {ctrl_freeze, ctrl_enable};
    cyc = 0;
    while (!got && cyc < 10) begin
      @(negedge aclk);
      if (bus.s_axi_bvalid) got = 1;
      else prev_c = {ctrl_freeze, ctrl_enable};
      cyc++;
    end
    if (!got) begin
      fail_timeout({name, "_bvalid"});
      return;
    end
    ctrl_before = prev_c;
    ctrl_at_b   = {ctrl_freeze, ctrl_enable};
    check({name, "_bresp"}, 32'(bus.s_axi_bresp), 32'(exp_resp));
    for (int h = 0; h < b_hold; h++) begin
      @(negedge aclk);
      check({name, "_bvalid_hold"}, 32'(bus.s_axi_bvalid), 32'd1);
      check({name, "_bresp_hold"}, 32'(bus.s_axi_bresp), 32'(exp_resp));
    end
    @(posedge aclk); #1; bus.s_axi_bready = 1'b1;
    @(posedge aclk); #1; bus.s_axi_bready = 1'b0;
    @(negedge aclk);
    check({name, "_bvalid_drop"}, 32'(bus.s_axi_bvalid), 32'd0);
    @(posedge aclk); #1;
  endtask

  // Called at posedge+1. rready held low r_hold cycles after rvalid.
  task automatic do_read(input logic [7:0] addr, input int r_hold,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp, input string name);
    bit hs;
    int cyc;
    hs = 0; cyc = 0;
    bus.s_axi_araddr  = addr;
    bus.s_axi_arvalid = 1'b1;
    bus.s_axi_rready  = 1'b0;
    while (!hs && cyc < 20) begin
      @(negedge aclk);
      hs = bus.s_axi_arready;
      @(posedge aclk); #1;
      cyc++;
    end
    bus.s_axi_arvalid = 1'b0;
    if (!hs) begin
      fail_timeout({name, "_ar"});
      return;
    end
    @(negedge aclk);
    check({name, "_rvalid_lat"}, 32'(bus.s_axi_rvalid), 32'd1);
    check({name, "_rdata"}, bus.s_axi_rdata, exp_data);
    check({name, "_rresp"}, 32'(bus.s_axi_rresp), 32'(exp_resp));
    for (int h = 0; h < r_hold; h++) begin
      @(negedge aclk);
      check({name, "_rdata_hold"}, bus.s_axi_rdata, exp_data);
    end
    @(posedge aclk); #1; bus.s_axi_rready = 1'b1;
    @(posedge aclk); #1; bus.s_axi_rready = 1'b0;
    @(negedge aclk);
    check({name, "_rvalid_drop"}, 32'(bus.s_axi_rvalid), 32'd0);
    @(posedge aclk); #1;
  endtask

  initial begin
    logic [31:0] md;
    logic [1:0]  mr;
    logic [7:0]  addr_pool [16];
    bit hs;
    int cyc;

    addr_pool = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h20, 8'h24, 8'h28,
                  8'h2C, 8'h30, 8'h34, 8'h58, 8'h5C, 8'h98, 8'h40, 8'hFC};

    bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata  = '0; bus.s_axi_wstrb   = '0; bus.s_axi_wvalid = 1'b0;
    bus.s_axi_bready = 1'b0;
    bus.s_axi_araddr = '0; bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;
    st[0] = 64'h1111_2222_3333_4444;
    st[1] = 64'h0000_0001_FFFF_FFFF;
    st[2] = 64'h5555_6666_7777_8888;
    st[3] = 64'h9999_AAAA_BBBB_CCCC;
    lat   = 32'h0000_1234;
    model_reset();

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_awready", 32'(bus.s_axi_awready), 32'd0);
    check("rst_arready", 32'(bus.s_axi_arready), 32'd0);
    check("rst_bvalid",  32'(bus.s_axi_bvalid), 32'd0);
    check("rst_rvalid",  32'(bus.s_axi_rvalid), 32'd0);
    check("rst_rdata",   bus.s_axi_rdata, 32'd0);
    check("rst_ctrl",    32'({ctrl_freeze, ctrl_enable}), 32'd0);
    @(posedge aclk); #1; rst = 1'b0;
    @(posedge aclk); #1;

    // Constant vector table
    vecs.push_back('{1'b0, 8'h00, 32'h0,        4'h0, 32'h0000A0A1, 2'b00});
    vecs.push_back('{1'b0, 8'h04, 32'h0,        4'h0, 32'h00010000, 2'b00});
    vecs.push_back('{1'b0, 8'h0C, 32'h0,        4'h0, 32'hFFFFFFFF, 2'b00});
    vecs.push_back('{1'b0, 8'h2C, 32'h0,        4'h0, 32'h00000000, 2'b00});
    vecs.push_back('{1'b1, 8'h0C, 32'h12345678, 4'hF, 32'h0,        2'b00});
    vecs.push_back('{1'b0, 8'h0C, 32'h0,        4'h0, 32'hEDCBA987, 2'b00});
    vecs.push_back('{1'b1, 8'h0C, 32'h000000FF, 4'h1, 32'h0,        2'b00});
    vecs.push_back('{1'b0, 8'h0C, 32'h0,        4'h0, 32'hEDCBA900, 2'b00});
    vecs.push_back('{1'b0, 8'h0F, 32'h0,        4'h0, 32'hEDCBA900, 2'b00});
    vecs.push_back('{1'b0, 8'h10, 32'h0,        4'h0, 32'h00000000, 2'b00});
    vecs.push_back('{1'b1, 8'h10, 32'hFFFFFFFF, 4'hE, 32'h0,        2'b00});
    vecs.push_back('{1'b0, 8'h10, 32'h0,        4'h0, 32'h00000000, 2'b00});
    vecs.push_back('{1'b0, 8'h40, 32'h0,        4'h0, 32'h00000000, 2'b10});
    vecs.push_back('{1'b0, 8'h08, 32'h0,        4'h0, 32'h00000000, 2'b10});
    vecs.push_back('{1'b1, 8'h00, 32'hDEADBEEF, 4'hF, 32'h0,        2'b10});
    vecs.push_back('{1'b0, 8'h00, 32'h0,        4'h0, 32'h0000A0A1, 2'b00});
    vecs.push_back('{1'b1, 8'h24, 32'h00000001, 4'hF, 32'h0,        2'b10});
    vecs.push_back('{1'b0, 8'h20, 32'h0,        4'h0, 32'h11112222, 2'b00});
    vecs.push_back('{1'b0, 8'h24, 32'h0,        4'h0, 32'h33334444, 2'b00});
    vecs.push_back('{1'b0, 8'h98, 32'h0,        4'h0, 32'h00001234, 2'b00});
    vecs.push_back('{1'b0, 8'h5C, 32'h0,        4'h0, 32'h00000000, 2'b00});
    vecs.push_back('{1'b0, 8'h58, 32'h0,        4'h0, 32'h9999AAAA, 2'b00});
    vecs.push_back('{1'b0, 8'h5C, 32'h0,        4'h0, 32'hBBBBCCCC, 2'b00});
    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        model_write(vecs[i].addr, vecs[i].data, vecs[i].strb, mr);
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, vecs[i].exp_resp,
                 $sformatf("vec%0d_wr", i));
      end else begin
        model_read(vecs[i].addr, md, mr);
        do_read(vecs[i].addr, 0, vecs[i].exp_data, vecs[i].exp_resp, $sformatf("vec%0d_rd", i));
      end
    end

    // W three cycles ahead of AW, bready held low five cycles
    model_write(8'h0C, 32'hA5A50000, 4'hF, mr);
    do_write(8'h0C, 32'hA5A50000, 4'hF, 0, 3, 5, 2'b00, "w_first");
    do_read(8'h0C, 2, 32'h5A5AFFFF, 2'b00, "w_first_rd");

    // CONTROL write: outputs change the cycle after commit
    model_write(8'h10, 32'h3, 4'hF, mr);
    do_write(8'h10, 32'h00000003, 4'hF, 1, 0, 0, 2'b00, "ctrl_wr");
    check("ctrl_commit_cycle", 32'(ctrl_before), 32'd0);
    check("ctrl_after_commit", 32'(ctrl_at_b), 32'd3);
    do_read(8'h10, 0, 32'h00000003, 2'b00, "ctrl_rd");

    // Hi/lo coherency with the live input changing between the reads
    st[1] = 64'h0000_0001_FFFF_FFFF;
    do_read(8'h28, 0, 32'h00000001, 2'b00, "coh_hi");
    st[1] = 64'h0000_0002_0000_0000;
    do_read(8'h2C, 0, 32'hFFFFFFFF, 2'b00, "coh_lo");
    model_read(8'h28, md, mr);
    do_read(8'h28, 0, 32'h00000002, 2'b00, "coh_hi2");
    do_read(8'h2C, 0, 32'h00000000, 2'b00, "coh_lo2");

    // Reset while a read response is pending
    bus.s_axi_araddr = 8'h00; bus.s_axi_arvalid = 1'b1; bus.s_axi_rready = 1'b0;
    hs = 0; cyc = 0;
    while (!hs && cyc < 20) begin
      @(negedge aclk); hs = bus.s_axi_arready;
      @(posedge aclk); #1; cyc++;
    end
    bus.s_axi_arvalid = 1'b0;
    if (!hs) fail_timeout("rst_mid_ar");
    @(negedge aclk);
    check("rst_mid_rvalid_before", 32'(bus.s_axi_rvalid), 32'd1);
    @(posedge aclk); #1; rst = 1'b1;
    @(posedge aclk); #1; rst = 1'b0;
    @(negedge aclk);
    check("rst_mid_rvalid", 32'(bus.s_axi_rvalid), 32'd0);
    check("rst_mid_ctrl", 32'({ctrl_freeze, ctrl_enable}), 32'd0);
    check("rst_mid_arready", 32'(bus.s_axi_arready), 32'd0);
    @(posedge aclk); #1;
    model_reset();
    do_read(8'h0C, 0, 32'hFFFFFFFF, 2'b00, "post_rst_flip");
    do_read(8'h5C, 0, 32'h00000000, 2'b00, "post_rst_shadow");

    // Randomized traffic against the model
    for (int it = 0; it < 200; it++) begin
      logic [7:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < 4; k++) st[k] = {$urandom, $urandom};
        lat = $urandom;
      end
      a = addr_pool[$urandom_range(0, 15)] | 8'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        model_write(a, d, s, mr);
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                 mr, $sformatf("rnd%0d_wr_%h", it, a));
      end else begin
        model_read(a, md, mr);
        do_read(a, $urandom_range(0, 2), md, mr, $sformatf("rnd%0d_rd_%h", it, a));
      end
      check($sformatf("rnd%0d_ctrl", it), 32'({ctrl_freeze, ctrl_enable}), 32'(m_ctrl));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
